mem_arbiter: RTL and testbench

Parametrised N-port arbiter that serialises load/store/fetch requests from several requesters onto the single request interface of the byte-serial memory controller. It generalises the two-client data-first front end: configurable port count, fixed-priority or round-robin arbitration, and a pipeline-flush input that aborts in-flight reads but never tears an in-flight store. It sits between the caches/LSB and the memory controller.

---
 rtl/mem_arbiter_if.sv | 32 +++
 rtl/mem_arbiter.sv | 86 ++++++++
 tb/tb_mem_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester-side and memory-controller-side signals of the arbiter
interface mem_arbiter_if #(
    parameter int N_PORTS = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
);
    logic [N_PORTS-1:0]        req_valid;
    logic [N_PORTS-1:0]        req_wr;
    logic [3*N_PORTS-1:0]      req_len;
    logic [ADDR_W*N_PORTS-1:0] req_addr;
    logic [DATA_W*N_PORTS-1:0] req_data;
    logic [N_PORTS-1:0]        req_ready;
    logic [DATA_W-1:0]         req_res;
    logic                      mc_valid;
    logic                      mc_wr;
    logic [2:0]                mc_len;
    logic [ADDR_W-1:0]         mc_addr;
    logic [DATA_W-1:0]         mc_data;
    logic                      mc_ready;
    logic [DATA_W-1:0]         mc_res;
    logic                      mc_abort;

    modport master (
        output req_valid, req_wr, req_len, req_addr, req_data, mc_ready, mc_res,
        input  req_ready, req_res, mc_valid, mc_wr, mc_len, mc_addr, mc_data, mc_abort
    );

    modport slave (
        input  req_valid, req_wr, req_len, req_addr, req_data, mc_ready, mc_res,
        output req_ready, req_res, mc_valid, mc_wr, mc_len, mc_addr, mc_data, mc_abort
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: N-port fixed/round-robin arbiter onto a single memory controller request port
module mem_arbiter #(
    parameter int N_PORTS = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int RR      = 1,
    localparam int GW     = N_PORTS > 1 ? $clog2(N_PORTS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rdy,
    input  logic          clear,
    mem_arbiter_if.slave  bus,
    output logic          busy,
    output logic [GW-1:0] grant_id
);
    typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

    state_t        state, next_state;
    logic [GW-1:0] last_grant, win;
    logic          any_req, done;
    int            idx;

    // Winner search; iterating backwards lets the first port in search order overwrite the rest
    always_comb begin
        win     = '0;
        idx     = 0;
        any_req = |bus.req_valid;
        for (int i = N_PORTS - 1; i >= 0; i--) begin
            idx = RR != 0 ? (int'(last_grant) + 1 + i) % N_PORTS : i;
            if (bus.req_valid[idx]) win = idx[GW-1:0];
        end
    end

    // State register, frozen while rdy is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else if (rdy) state <= next_state;
    end

    // Next state: a store caught by a flush drains instead of being torn
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (any_req && !clear) next_state = BUSY;
            BUSY:    if (clear) next_state = (bus.mc_wr && !bus.mc_ready) ? DRAIN : IDLE;
                     else if (bus.mc_ready) next_state = IDLE;
            DRAIN:   if (bus.mc_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs: completion only in BUSY without flush, abort only for a flushed read
    always_comb begin
        done = state == BUSY && bus.mc_ready && !clear && rdy;
        for (int i = 0; i < N_PORTS; i++) bus.req_ready[i] = done && int'(grant_id) == i;
        bus.req_res  = bus.mc_res;
        bus.mc_abort = state == BUSY && !bus.mc_wr && clear && rdy;
        busy         = state != IDLE;
    end

    // Request latch and grant bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.mc_valid <= 1'b0;
            bus.mc_wr    <= 1'b0;
            bus.mc_len   <= '0;
            bus.mc_addr  <= '0;
            bus.mc_data  <= '0;
            grant_id     <= '0;
            last_grant   <= GW'(N_PORTS - 1);
        end else if (rdy) begin
            if (state == IDLE && next_state == BUSY) begin
                bus.mc_valid <= 1'b1;
                bus.mc_wr    <= bus.req_wr[win];
                bus.mc_len   <= bus.req_len[int'(win)*3 +: 3];
                bus.mc_addr  <= bus.req_addr[int'(win)*ADDR_W +: ADDR_W];
                bus.mc_data  <= bus.req_data[int'(win)*DATA_W +: DATA_W];
                grant_id     <= win;
                last_grant   <= win;
            end else if (state != IDLE && next_state == IDLE) begin
                bus.mc_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven and directed checks of round-robin and fixed-priority arbiters
module tb_mem_arbiter;
    logic       clk = 1'b0, rst_n = 1'b0, rdy = 1'b1, clear = 1'b0;
    logic       busy_r, busy_f, gid_f;
    logic [1:0] gid_r;
    int         n_vec = 0, n_bad = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.N_PORTS(3), .ADDR_W(32), .DATA_W(32)) rb();
    mem_arbiter_if #(.N_PORTS(2), .ADDR_W(32), .DATA_W(32)) fb();

    mem_arbiter #(.N_PORTS(3), .ADDR_W(32), .DATA_W(32), .RR(1)) u_rr (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .clear(clear), .bus(rb), .busy(busy_r), .grant_id(gid_r)
    );
    mem_arbiter #(.N_PORTS(2), .ADDR_W(32), .DATA_W(32), .RR(0)) u_fx (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .clear(clear), .bus(fb), .busy(busy_f), .grant_id(gid_f)
    );

    // in = {valid[2:0], wr[2:0], clear, mc_ready}; ctl = {busy, mc_valid, grant_id[1:0], req_ready[2:0], mc_abort, mc_wr}
    typedef struct {
        logic [7:0]  in;
        logic [8:0]  ctl;
        logic [31:0] addr;
    } vec_t;

    vec_t tbl[26];

    function automatic vec_t mk(input logic [7:0] in, input logic [8:0] ctl, input logic [31:0] addr);
        return '{in, ctl, addr};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        tbl[0]  = mk(8'b111_000_0_0, 9'b0_0_00_000_0_0, 32'h000);
        tbl[1]  = mk(8'b111_000_0_0, 9'b1_1_00_000_0_0, 32'h100);
        tbl[2]  = mk(8'b111_000_0_1, 9'b1_1_00_001_0_0, 32'h100);
        tbl[3]  = mk(8'b111_000_0_0, 9'b0_0_00_000_0_0, 32'h100);
        tbl[4]  = mk(8'b111_000_0_0, 9'b1_1_01_000_0_0, 32'h200);
        tbl[5]  = mk(8'b111_000_0_1, 9'b1_1_01_010_0_0, 32'h200);
        tbl[6]  = mk(8'b111_000_0_0, 9'b0_0_01_000_0_0, 32'h200);
        tbl[7]  = mk(8'b111_000_0_0, 9'b1_1_10_000_0_0, 32'h300);
        tbl[8]  = mk(8'b111_000_0_1, 9'b1_1_10_100_0_0, 32'h300);
        tbl[9]  = mk(8'b111_000_0_0, 9'b0_0_10_000_0_0, 32'h300);
        tbl[10] = mk(8'b111_000_0_0, 9'b1_1_00_000_0_0, 32'h100);
        tbl[11] = mk(8'b111_000_0_1, 9'b1_1_00_001_0_0, 32'h100);
        tbl[12] = mk(8'b100_000_0_0, 9'b0_0_00_000_0_0, 32'h100);
        tbl[13] = mk(8'b100_000_0_0, 9'b1_1_10_000_0_0, 32'h300);
        tbl[14] = mk(8'b100_000_0_1, 9'b1_1_10_100_0_0, 32'h300);
        tbl[15] = mk(8'b010_000_0_0, 9'b0_0_10_000_0_0, 32'h300);
        tbl[16] = mk(8'b000_000_1_1, 9'b1_1_01_000_1_0, 32'h200);
        tbl[17] = mk(8'b000_000_0_0, 9'b0_0_01_000_0_0, 32'h200);
        tbl[18] = mk(8'b001_000_1_0, 9'b0_0_01_000_0_0, 32'h200);
        tbl[19] = mk(8'b001_001_0_0, 9'b0_0_01_000_0_0, 32'h200);
        tbl[20] = mk(8'b001_001_1_0, 9'b1_1_00_000_0_1, 32'h100);
        tbl[21] = mk(8'b011_001_1_0, 9'b1_1_00_000_0_1, 32'h100);
        tbl[22] = mk(8'b011_001_0_1, 9'b1_1_00_000_0_1, 32'h100);
        tbl[23] = mk(8'b010_010_0_0, 9'b0_0_00_000_0_1, 32'h100);
        tbl[24] = mk(8'b010_010_1_1, 9'b1_1_01_000_0_1, 32'h200);
        tbl[25] = mk(8'b000_000_0_0, 9'b0_0_01_000_0_1, 32'h200);

        rb.req_valid = '0; rb.req_wr = '0; rb.mc_ready = 1'b0; rb.mc_res = 32'h5A5A5A5A;
        rb.req_len   = {3'd2, 3'd1, 3'd0};
        rb.req_addr  = {32'h300, 32'h200, 32'h100};
        rb.req_data  = {32'hA2, 32'hA1, 32'hA0};
        fb.req_valid = '0; fb.req_wr = '0; fb.mc_ready = 1'b0; fb.mc_res = 32'h0;
        fb.req_len   = '0;
        fb.req_addr  = {32'h200, 32'h100};
        fb.req_data  = {32'hB1, 32'hB0};

        repeat (2) @(negedge clk);
        chk("reset_rr", {busy_r, rb.mc_valid, gid_r, rb.req_ready, rb.mc_abort, rb.mc_wr, rb.mc_addr}, 64'h0);
        chk("reset_fx", {busy_f, fb.mc_valid, gid_f, fb.req_ready, fb.mc_abort, fb.mc_addr}, 64'h0);
        rst_n = 1'b1;

        for (int k = 0; k < 26; k++) begin
            @(negedge clk);
            {rb.req_valid, rb.req_wr, clear, rb.mc_ready} = tbl[k].in;
            #1;
            chk($sformatf("vec%0d", k),
                {busy_r, rb.mc_valid, gid_r, rb.req_ready, rb.mc_abort, rb.mc_wr, rb.mc_addr},
                {tbl[k].ctl, tbl[k].addr});
        end

        // Flushed read: abort pulse, no completion even with coincident mc_ready
        @(negedge clk);
        rb.req_addr[31:0] = 32'h1000; rb.req_valid = 3'b001; rb.req_wr = 3'b000;
        @(negedge clk); rb.req_valid = 3'b000; #1;
        chk("abort_grant", {busy_r, gid_r, rb.mc_wr, rb.mc_addr}, {1'b1, 2'd0, 1'b0, 32'h1000});
        @(negedge clk);
        @(negedge clk); clear = 1'b1; rb.mc_ready = 1'b1; #1;
        chk("abort_pulse", {rb.mc_abort, rb.req_ready}, {1'b1, 3'b000});
        @(negedge clk); clear = 1'b0; rb.mc_ready = 1'b0; #1;
        chk("abort_after", {rb.mc_abort, rb.mc_valid, busy_r, rb.req_ready}, 64'h0);

        // Flushed store drains with fields held
        @(negedge clk);
        rb.req_addr[63:32] = 32'h30000; rb.req_data[63:32] = 32'hDEADBEEF;
        rb.req_valid = 3'b010; rb.req_wr = 3'b010;
        @(negedge clk); rb.req_valid = 3'b000; clear = 1'b1; #1;
        chk("drain_grant", {busy_r, gid_r, rb.mc_wr, rb.mc_abort}, {1'b1, 2'd1, 1'b1, 1'b0});
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); rb.req_valid = 3'b111; clear = k[0]; #1;
            chk($sformatf("drain_hold%0d", k), {busy_r, rb.mc_valid, gid_r, rb.mc_addr, rb.mc_data},
                {1'b1, 1'b1, 2'd1, 32'h30000, 32'hDEADBEEF});
        end
        @(negedge clk); rb.req_valid = 3'b000; clear = 1'b0; rb.mc_ready = 1'b1; #1;
        chk("drain_noready", {busy_r, rb.req_ready}, {1'b1, 3'b000});
        @(negedge clk); rb.mc_ready = 1'b0; #1;
        chk("drain_idle", {busy_r, rb.mc_valid}, 64'h0);

        // rdy low freezes everything mid-BUSY
        @(negedge clk); rb.req_valid = 3'b100; rb.req_wr = 3'b000;
        @(negedge clk); rb.req_valid = 3'b000; #1;
        chk("rdy_grant", {busy_r, gid_r, rb.mc_addr}, {1'b1, 2'd2, 32'h300});
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); rdy = 1'b0; rb.req_valid = 3'b011; clear = 1'b1; #1;
            chk($sformatf("rdy_freeze%0d", k), {busy_r, rb.mc_valid, gid_r, rb.mc_abort, rb.mc_addr},
                {1'b1, 1'b1, 2'd2, 1'b0, 32'h300});
        end
        @(negedge clk); rdy = 1'b1; rb.req_valid = 3'b000; clear = 1'b0; #1;
        chk("rdy_resume", {busy_r, rb.mc_valid, gid_r}, {1'b1, 1'b1, 2'd2});
        @(negedge clk); rb.mc_ready = 1'b1; rb.mc_res = 32'hCAFEF00D; #1;
        chk("rdy_done", {rb.req_ready, rb.req_res}, {3'b100, 32'hCAFEF00D});
        @(negedge clk); rb.mc_ready = 1'b0; #1;
        chk("rdy_idle", {busy_r, rb.mc_valid}, 64'h0);

        // Asynchronous reset mid-write, then first round-robin grant goes to port 0
        @(negedge clk); rb.req_valid = 3'b010; rb.req_wr = 3'b010;
        @(negedge clk); rb.req_valid = 3'b000; #1;
        chk("rst_busy", {busy_r, gid_r, rb.mc_wr}, {1'b1, 2'd1, 1'b1});
        #2 rst_n = 1'b0; #1;
        chk("rst_async", {busy_r, rb.mc_valid, rb.mc_wr, rb.mc_len, rb.mc_addr, rb.mc_data, gid_r, rb.req_ready, rb.mc_abort}, 64'h0);
        @(negedge clk); rst_n = 1'b1; rb.req_valid = 3'b111; rb.req_wr = 3'b000;
        @(negedge clk); #1;
        chk("rst_first", {busy_r, gid_r, rb.mc_len}, {1'b1, 2'd0, 3'd0});
        rb.mc_ready = 1'b1; #1;
        chk("rst_done", rb.req_ready, 64'b001);
        @(negedge clk); rb.mc_ready = 1'b0; rb.req_valid = 3'b000;

        // Fixed priority: port 0 wins again while held, port 1 only after port 0 drops
        @(negedge clk); fb.req_valid = 2'b11;
        @(negedge clk); #1;
        chk("fx_first", {busy_f, gid_f, fb.mc_addr}, {1'b1, 1'b0, 32'h100});
        fb.mc_ready = 1'b1; #1;
        chk("fx_ready0", fb.req_ready, 64'b01);
        @(negedge clk); fb.mc_ready = 1'b0; #1;
        chk("fx_gap", busy_f, 64'h0);
        @(negedge clk); #1;
        chk("fx_regrant", {busy_f, gid_f, fb.mc_addr}, {1'b1, 1'b0, 32'h100});
        fb.mc_ready = 1'b1;
        @(negedge clk); fb.mc_ready = 1'b0; fb.req_valid = 2'b10;
        @(negedge clk); #1;
        chk("fx_port1", {busy_f, gid_f, fb.mc_addr}, {1'b1, 1'b1, 32'h200});
        fb.mc_ready = 1'b1; #1;
        chk("fx_ready1", fb.req_ready, 64'b10);
        @(negedge clk); fb.mc_ready = 1'b0; fb.req_valid = 2'b00;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
